regfile_port_arbiter: RTL and testbench
=======================================

Name: regfile_port_arbiter

Overview:
Shares the 8x16 register file's single write port (A, with the flags side-write) and read port B between two requesters: the core writeback stage and the debug host. The core has priority. A streak counter guarantees the debug host a grant after a bounded number of consecutive core grants. Debug reads return through a registered response channel with a valid/ready handshake. The block sits between the writeback stage, the debug UART bridge and the register file.

Parameters:
MaxCoreStreak, 4, max consecutive core grants while a debug request is pending (1..15)
FlagsAddress, 7, register index holding the flags

Ports:
Clk  in  1  clock, all state on posedge
Reset  in  1  synchronous, active-high
CoreReqValid  in  1  core write request
CoreReqAddr  in  3  destination register
CoreReqData  in  16  write data
CoreReqUpdFlags  in  1  also write flags
CoreReqFlags  in  16  new flags value
CoreReqReady  out  1  core request accepted this cycle
DbgReqValid  in  1  debug request
DbgReqWrite  in  1  1=write, 0=read
DbgReqAddr  in  3  register index
DbgReqData  in  16  debug write data
DbgReqReady  out  1  debug request accepted this cycle
DbgRspValid  out  1  read data valid
DbgRspData  out  16  read data
DbgRspReady  in  1  host accepts response
RfAddrA  out  3  register file write address
RfInDataA  out  16  register file write data
RfWrEn  out  1  register file write strobe (write port gated by it)
RfInNewFlags  out  16  flags write data
RfUpdateFlags  out  1  flags write strobe
RfAddrB  out  3  register file read address
RfOutDataB  in  16  register file read data (combinational)

Behaviour:
- FSM states: IDLE (response channel free) and RSP_WAIT (debug read response held).
- Reset: state IDLE, streak counter 0, DbgRspValid 0, DbgRspData 0. Combinational outputs are driven from the reset-state values.
- Grant is combinational within a cycle. DbgOk = DbgReqValid and (state==IDLE or DbgReqWrite).
- Debug wins when DbgOk and (streak==MaxCoreStreak or not CoreReqValid). Otherwise the core wins if CoreReqValid.
- CoreReqReady and DbgReqReady equal the respective grant. At most one is high per cycle.
- Core grant: RfWrEn=1, RfAddrA=CoreReqAddr, RfInDataA=CoreReqData, RfUpdateFlags=CoreReqUpdFlags, RfInNewFlags=CoreReqFlags.
- Debug write grant: RfWrEn=1, RfAddrA=DbgReqAddr, RfInDataA=DbgReqData, RfUpdateFlags=0.
- Debug read grant: RfWrEn=0, RfAddrB=DbgReqAddr. RfOutDataB is captured into DbgRspData at the posedge. DbgRspValid=1 and state goes to RSP_WAIT (latency 1 cycle).
- No grant: RfWrEn=0, RfUpdateFlags=0. RfAddrA, RfInDataA and RfInNewFlags are 0. RfAddrB holds the last debug read address (0 after reset).
- RSP_WAIT: DbgRspData is held stable. On DbgRspValid and DbgRspReady, DbgRspValid goes to 0 next cycle and the state returns to IDLE. No new debug read is granted in RSP_WAIT; debug writes and core writes are still granted.
- Streak counter:
  - increments on a core grant while DbgReqValid=1;
  - saturates at MaxCoreStreak;
  - clears on any debug grant, or when DbgReqValid=0.
- Core write to FlagsAddress with CoreReqUpdFlags=1: both strobes are issued; the flags value wins in the register file.
- A debug read in the same cycle as a core write cannot occur (single grant). A debug read in the cycle after a core write returns the new value.
- Reset asserted mid-response drops DbgRspValid and returns to IDLE. A pending request is not remembered; the requester re-presents it.
- Requesters hold Valid and payload stable until Ready. The arbiter does not check this.

Decomposition:
- Shared package holds: register index width (3), data width (16), FlagsAddress constant, FSM state encoding (IDLE, RSP_WAIT).
- One natural sub-module: regfile_streak_counter (saturating counter with increment/clear, compare to MaxCoreStreak).

Test Plan:
- Reset, then debug write R3=0x1234; debug read R3 -> one cycle later DbgRspValid=1, DbgRspData=0x1234. Hold DbgRspReady=0 for 3 cycles -> data stable; then ready -> valid drops next cycle.
- Core valid every cycle (R1 = 1,2,3,...) plus debug read R1 pending -> core granted 4 cycles, debug granted on cycle 5. The returned value equals the 4th core write; the streak then restarts.
- In RSP_WAIT, debug write R2=0xBEEF plus core write R5=0x0005 -> core granted first, debug write next cycle. Readback R2=0xBEEF, R5=0x0005.
- Core write R7=0x0001 with UpdFlags=1, flags 0x8000 -> RfWrEn=1, RfUpdateFlags=1. Debug read R7 returns 0x8000.
- Core request with no debug request -> CoreReqReady=1 same cycle; streak stays 0 for 20 cycles; DbgReqReady=0.
- Reset asserted while DbgRspValid=1 -> next cycle DbgRspValid=0, state IDLE. A new debug read is granted immediately after reset deasserts.

Source files
------------

// File: rtl/regfile_port_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// regfile_port_arbiter_pkg
//
// Shared definitions for the register-file port arbiter and its streak
// counter:
//   - register index and data widths of the 8x16 register file
//   - default index of the flags register
//   - width of the core-streak counter (enough for a limit of 1..15)
//   - response-channel FSM state encoding
// ----------------------------------------------------------------------------
package regfile_port_arbiter_pkg;

    // Register file geometry
    localparam int unsigned RegAddrWidth = 3;
    localparam int unsigned DataWidth    = 16;

    // Register index that holds the flags
    localparam logic [RegAddrWidth-1:0] DefaultFlagsAddress = 3'd7;

    // Streak counter width; supports a core-streak limit of up to 15
    localparam int unsigned StreakWidth = 4;

    // Response channel state: free, or holding an unaccepted debug read result
    typedef enum logic {
        StIdle    = 1'b0,
        StRspWait = 1'b1
    } arbState_t;

endpackage

// File: rtl/regfile_streak_counter.sv
// ----------------------------------------------------------------------------
// regfile_streak_counter
//
// Counts consecutive core grants made while the debug host is waiting. The
// count saturates at MaxCoreStreak; AtMax tells the arbiter that the debug
// host must win the next arbitration it is eligible for.
//
// Ports:
//   Clk    in   clock, all state on posedge
//   Reset  in   synchronous, active-high; clears the count
//   Inc    in   core grant while a debug request is pending
//   Clear  in   debug grant, or no debug request pending
//   AtMax  out  count has reached MaxCoreStreak
// ----------------------------------------------------------------------------
module regfile_streak_counter
    import regfile_port_arbiter_pkg::*;
#(
    parameter int unsigned MaxCoreStreak = 4
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Inc,
    input  logic Clear,
    output logic AtMax
);

    localparam logic [StreakWidth-1:0] MaxCount = StreakWidth'(MaxCoreStreak);

    logic [StreakWidth-1:0] countQ;

    // Clear has priority over Inc; the two are never meant to coincide, but a
    // debug grant must always restart the streak.
    always_ff @(posedge Clk) begin
        if (Reset || Clear) begin
            countQ <= '0;
        end else if (Inc && (countQ != MaxCount)) begin
            countQ <= countQ + StreakWidth'(1);
        end
    end

    assign AtMax = (countQ == MaxCount);

endmodule

// File: rtl/regfile_port_arbiter.sv
// ----------------------------------------------------------------------------
// regfile_port_arbiter
//
// Shares the register file's write port A (with the flags side-write) and
// read port B between the core writeback stage and the debug host. The core
// has priority, but after MaxCoreStreak consecutive core grants with a debug
// request pending, the debug host wins. Debug reads return through a
// registered response channel with a valid/ready handshake; while a response
// is held, further debug reads are refused but writes from either side are
// still granted.
//
// Ports:
//   Clk, Reset                      clock; synchronous active-high reset
//   CoreReqValid/Addr/Data          core write request
//   CoreReqUpdFlags/Flags           optional flags side-write
//   CoreReqReady                    core request accepted this cycle
//   DbgReqValid/Write/Addr/Data     debug read or write request
//   DbgReqReady                     debug request accepted this cycle
//   DbgRspValid/Data, DbgRspReady   debug read response channel
//   RfAddrA/RfInDataA/RfWrEn        register file write port
//   RfInNewFlags/RfUpdateFlags      register file flags write
//   RfAddrB, RfOutDataB             register file read port (combinational)
// ----------------------------------------------------------------------------
module regfile_port_arbiter
    import regfile_port_arbiter_pkg::*;
#(
    parameter int unsigned              MaxCoreStreak = 4,
    parameter logic [RegAddrWidth-1:0]  FlagsAddress  = DefaultFlagsAddress
) (
    input  logic                    Clk,
    input  logic                    Reset,

    // Core writeback requester
    input  logic                    CoreReqValid,
    input  logic [RegAddrWidth-1:0] CoreReqAddr,
    input  logic [DataWidth-1:0]    CoreReqData,
    input  logic                    CoreReqUpdFlags,
    input  logic [DataWidth-1:0]    CoreReqFlags,
    output logic                    CoreReqReady,

    // Debug host requester
    input  logic                    DbgReqValid,
    input  logic                    DbgReqWrite,
    input  logic [RegAddrWidth-1:0] DbgReqAddr,
    input  logic [DataWidth-1:0]    DbgReqData,
    output logic                    DbgReqReady,

    // Debug read response
    output logic                    DbgRspValid,
    output logic [DataWidth-1:0]    DbgRspData,
    input  logic                    DbgRspReady,

    // Register file side
    output logic [RegAddrWidth-1:0] RfAddrA,
    output logic [DataWidth-1:0]    RfInDataA,
    output logic                    RfWrEn,
    output logic [DataWidth-1:0]    RfInNewFlags,
    output logic                    RfUpdateFlags,
    output logic [RegAddrWidth-1:0] RfAddrB,
    input  logic [DataWidth-1:0]    RfOutDataB
);

    arbState_t               stateQ;
    logic [RegAddrWidth-1:0] rdAddrQ;

    logic streakAtMax;
    logic dbgOk;
    logic dbgGrant;
    logic coreGrant;
    logic dbgRead;
    logic dbgWrite;

    // ------------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------------

    // A debug read needs the response channel; a debug write does not.
    assign dbgOk     = DbgReqValid && ((stateQ == StIdle) || DbgReqWrite);
    assign dbgGrant  = dbgOk && (streakAtMax || !CoreReqValid);
    assign coreGrant = CoreReqValid && !dbgGrant;
    assign dbgRead   = dbgGrant && !DbgReqWrite;
    assign dbgWrite  = dbgGrant && DbgReqWrite;

    assign CoreReqReady = coreGrant;
    assign DbgReqReady  = dbgGrant;

    // Only streaks that actually delay a waiting debug request are counted.
    regfile_streak_counter #(
        .MaxCoreStreak (MaxCoreStreak)
    ) uStreak (
        .Clk   (Clk),
        .Reset (Reset),
        .Inc   (coreGrant && DbgReqValid),
        .Clear (dbgGrant || !DbgReqValid),
        .AtMax (streakAtMax)
    );

    // ------------------------------------------------------------------------
    // Register file port steering
    // ------------------------------------------------------------------------
    always_comb begin
        RfWrEn        = 1'b0;
        RfAddrA       = '0;
        RfInDataA     = '0;
        RfUpdateFlags = 1'b0;
        RfInNewFlags  = '0;
        // Port B parks on the last debug read address between reads.
        RfAddrB       = rdAddrQ;

        if (coreGrant) begin
            RfWrEn        = 1'b1;
            RfAddrA       = CoreReqAddr;
            RfInDataA     = CoreReqData;
            RfUpdateFlags = CoreReqUpdFlags;
            RfInNewFlags  = CoreReqFlags;
        end else if (dbgWrite) begin
            RfWrEn    = 1'b1;
            RfAddrA   = DbgReqAddr;
            RfInDataA = DbgReqData;
        end else if (dbgRead) begin
            RfAddrB = DbgReqAddr;
        end
    end

    // ------------------------------------------------------------------------
    // Response channel FSM with registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            stateQ      <= StIdle;
            DbgRspValid <= 1'b0;
            DbgRspData  <= '0;
            rdAddrQ     <= '0;
        end else begin
            if (dbgRead) begin
                rdAddrQ <= DbgReqAddr;
            end
            unique case (stateQ)
                StIdle: begin
                    if (dbgRead) begin
                        stateQ      <= StRspWait;
                        DbgRspValid <= 1'b1;
                        DbgRspData  <= RfOutDataB;
                    end
                end
                StRspWait: begin
                    // Data stays put until the host takes it.
                    if (DbgRspValid && DbgRspReady) begin
                        stateQ      <= StIdle;
                        DbgRspValid <= 1'b0;
                    end
                end
                default: begin
                    stateQ      <= StIdle;
                    DbgRspValid <= 1'b0;
                end
            endcase
        end
    end

    // A core write to the flags register with the side-write set must drive
    // both strobes; the register file resolves the collision in favour of
    // the flags value.
    always_ff @(posedge Clk) begin
        if (!Reset && coreGrant && CoreReqUpdFlags && (CoreReqAddr == FlagsAddress)) begin
            assert (RfWrEn && RfUpdateFlags);
        end
    end

endmodule

// File: tb/tb_regfile_port_arbiter.sv
module tb_regfile_port_arbiter;

    localparam int MaxStreak = 4;
    localparam int FlagsIdx  = 7;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        CoreReqValid;
    logic [2:0]  CoreReqAddr;
    logic [15:0] CoreReqData;
    logic        CoreReqUpdFlags;
    logic [15:0] CoreReqFlags;
    logic        CoreReqReady;
    logic        DbgReqValid;
    logic        DbgReqWrite;
    logic [2:0]  DbgReqAddr;
    logic [15:0] DbgReqData;
    logic        DbgReqReady;
    logic        DbgRspValid;
    logic [15:0] DbgRspData;
    logic        DbgRspReady;
    logic [2:0]  RfAddrA;
    logic [15:0] RfInDataA;
    logic        RfWrEn;
    logic [15:0] RfInNewFlags;
    logic        RfUpdateFlags;
    logic [2:0]  RfAddrB;
    logic [15:0] RfOutDataB;

    always #5 Clk = ~Clk;

    regfile_port_arbiter #(
        .MaxCoreStreak (MaxStreak),
        .FlagsAddress  (3'd7)
    ) dut (
        .Clk             (Clk),
        .Reset           (Reset),
        .CoreReqValid    (CoreReqValid),
        .CoreReqAddr     (CoreReqAddr),
        .CoreReqData     (CoreReqData),
        .CoreReqUpdFlags (CoreReqUpdFlags),
        .CoreReqFlags    (CoreReqFlags),
        .CoreReqReady    (CoreReqReady),
        .DbgReqValid     (DbgReqValid),
        .DbgReqWrite     (DbgReqWrite),
        .DbgReqAddr      (DbgReqAddr),
        .DbgReqData      (DbgReqData),
        .DbgReqReady     (DbgReqReady),
        .DbgRspValid     (DbgRspValid),
        .DbgRspData      (DbgRspData),
        .DbgRspReady     (DbgRspReady),
        .RfAddrA         (RfAddrA),
        .RfInDataA       (RfInDataA),
        .RfWrEn          (RfWrEn),
        .RfInNewFlags    (RfInNewFlags),
        .RfUpdateFlags   (RfUpdateFlags),
        .RfAddrB         (RfAddrB),
        .RfOutDataB      (RfOutDataB)
    );

    // Register file the arbiter drives; flags write lands after the data write.
    logic        tbInit;
    logic [15:0] rfMem [8];
    assign RfOutDataB = rfMem[RfAddrB];
    always @(posedge Clk) begin
        if (tbInit) begin
            for (int i = 0; i < 8; i++) rfMem[i] <= '0;
        end else begin
            if (RfWrEn) rfMem[RfAddrA] <= RfInDataA;
            if (RfUpdateFlags) rfMem[FlagsIdx] <= RfInNewFlags;
        end
    end

    // Reference model state
    logic [15:0] mRegs [8];
    int          mStreak;
    logic        mRspValid;
    logic [15:0] mRspData;
    logic [2:0]  mLastRd;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic setCore(input logic v, input logic [2:0] a, input logic [15:0] d,
                           input logic u, input logic [15:0] f);
        CoreReqValid = v; CoreReqAddr = a; CoreReqData = d;
        CoreReqUpdFlags = u; CoreReqFlags = f;
    endtask

    task automatic setDbg(input logic v, input logic w, input logic [2:0] a,
                          input logic [15:0] d);
        DbgReqValid = v; DbgReqWrite = w; DbgReqAddr = a; DbgReqData = d;
    endtask

    // Called at a negedge with inputs driven: checks all outputs against the
    // model, advances the model, and returns at the next negedge.
    task automatic step();
        logic        eDbg, eCore, eRd, eWr;
        logic [15:0] eAddrA, eDataA, eFlags, eAddrB;
        #1;
        eDbg  = DbgReqValid && (!mRspValid || DbgReqWrite)
                && ((mStreak == MaxStreak) || !CoreReqValid);
        eCore = CoreReqValid && !eDbg;
        eRd   = eDbg && !DbgReqWrite;
        eWr   = eDbg && DbgReqWrite;
        eAddrA = '0; eDataA = '0; eFlags = '0; eAddrB = {13'd0, mLastRd};
        if (eCore) begin
            eAddrA = {13'd0, CoreReqAddr}; eDataA = CoreReqData; eFlags = CoreReqFlags;
        end else if (eWr) begin
            eAddrA = {13'd0, DbgReqAddr}; eDataA = DbgReqData;
        end
        if (eRd) eAddrB = {13'd0, DbgReqAddr};

        check("CoreReqReady", {15'd0, CoreReqReady}, {15'd0, eCore});
        check("DbgReqReady", {15'd0, DbgReqReady}, {15'd0, eDbg});
        check("RfWrEn", {15'd0, RfWrEn}, {15'd0, eCore || eWr});
        check("RfUpdateFlags", {15'd0, RfUpdateFlags}, {15'd0, eCore && CoreReqUpdFlags});
        check("RfAddrA", {13'd0, RfAddrA}, eAddrA);
        check("RfInDataA", RfInDataA, eDataA);
        check("RfInNewFlags", RfInNewFlags, eFlags);
        check("RfAddrB", {13'd0, RfAddrB}, eAddrB);
        check("DbgRspValid", {15'd0, DbgRspValid}, {15'd0, mRspValid});
        check("DbgRspData", DbgRspData, mRspData);

        if (Reset) begin
            mRspValid = 1'b0; mRspData = '0; mStreak = 0; mLastRd = '0;
        end else begin
            if (eRd) begin
                mRspValid = 1'b1; mRspData = mRegs[DbgReqAddr]; mLastRd = DbgReqAddr;
            end else if (mRspValid && DbgRspReady) begin
                mRspValid = 1'b0;
            end
            if (eDbg || !DbgReqValid) mStreak = 0;
            else if (eCore && mStreak < MaxStreak) mStreak++;
        end
        if (eCore) begin
            mRegs[CoreReqAddr] = CoreReqData;
            if (CoreReqUpdFlags) mRegs[FlagsIdx] = CoreReqFlags;
        end else if (eWr) begin
            mRegs[DbgReqAddr] = DbgReqData;
        end
        @(posedge Clk);
        @(negedge Clk);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mRegs[i] = '0;
        mStreak = 0; mRspValid = 1'b0; mRspData = '0; mLastRd = '0;
        Reset = 1'b1; tbInit = 1'b1; DbgRspReady = 1'b0;
        setCore(0, 0, 0, 0, 0);
        setDbg(0, 0, 0, 0);
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        step();                                 // reset-state outputs
        Reset = 1'b0; tbInit = 1'b0;

        // Debug write R3, read it back, hold the response, then accept it
        setDbg(1, 1, 3, 16'h1234); step();
        setDbg(1, 0, 3, 0); step();
        setDbg(0, 0, 0, 0);
        check("RspR3Valid", {15'd0, DbgRspValid}, 16'd1);
        check("RspR3Data", DbgRspData, 16'h1234);
        repeat (3) step();
        check("RspR3Held", DbgRspData, 16'h1234);
        DbgRspReady = 1'b1; step();
        check("RspR3Dropped", {15'd0, DbgRspValid}, 16'd0);

        // Core streak of 4 then the pending debug read of R1 wins
        for (int i = 1; i <= 5; i++) begin
            setCore(1, 1, 16'(i), 0, 0);
            setDbg(1, 0, 1, 0);
            #1;
            check("StreakDbgGrant", {15'd0, DbgReqReady}, {15'd0, i == 5});
            step();
        end
        setDbg(0, 0, 0, 0);
        check("StreakReadData", DbgRspData, 16'd4);
        setCore(1, 1, 16'd5, 0, 0); step();
        setCore(0, 0, 0, 0, 0); step();

        // While a response is held, core write wins first, debug write next
        DbgRspReady = 1'b0;
        setDbg(1, 0, 0, 0); step();
        setCore(1, 5, 16'h0005, 0, 0);
        setDbg(1, 1, 2, 16'hBEEF);
        #1 check("RspWaitCoreFirst", {15'd0, CoreReqReady}, 16'd1);
        step();
        setCore(0, 0, 0, 0, 0);
        #1 check("RspWaitDbgWrite", {15'd0, DbgReqReady}, 16'd1);
        step();
        setDbg(0, 0, 0, 0); DbgRspReady = 1'b1; step();
        setDbg(1, 0, 2, 0); step();
        setDbg(0, 0, 0, 0);
        check("ReadR2", DbgRspData, 16'hBEEF);
        step();
        setDbg(1, 0, 5, 0); step();
        setDbg(0, 0, 0, 0);
        check("ReadR5", DbgRspData, 16'h0005);
        step();

        // Core write to the flags register with flags side-write
        setCore(1, 7, 16'h0001, 1, 16'h8000); step();
        setCore(0, 0, 0, 0, 0);
        setDbg(1, 0, 7, 0); step();
        setDbg(0, 0, 0, 0);
        check("ReadFlags", DbgRspData, 16'h8000);
        step();

        // Core alone: granted every cycle, debug never
        for (int i = 0; i < 20; i++) begin
            setCore(1, 3'($urandom_range(0, 6)), 16'($urandom), 0, 0);
            step();
        end
        setCore(0, 0, 0, 0, 0);

        // Reset in the middle of a held response
        DbgRspReady = 1'b0;
        setDbg(1, 0, 4, 0); step();
        setDbg(0, 0, 0, 0);
        Reset = 1'b1; step();
        Reset = 1'b0;
        check("ResetDropsValid", {15'd0, DbgRspValid}, 16'd0);
        setDbg(1, 0, 4, 0);
        #1 check("ReadAfterReset", {15'd0, DbgReqReady}, 16'd1);
        step();
        setDbg(0, 0, 0, 0);
        check("ReadAfterResetValid", {15'd0, DbgRspValid}, 16'd1);
        step();

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            Reset = ($urandom_range(0, 49) == 0);
            DbgRspReady = $urandom_range(0, 1) == 1;
            if (Reset) begin
                setCore(0, 0, 0, 0, 0);
                setDbg(0, 0, 0, 0);
            end else begin
                setCore($urandom_range(0, 3) != 0, 3'($urandom), 16'($urandom),
                        $urandom_range(0, 3) == 0, 16'($urandom));
                setDbg($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                       3'($urandom), 16'($urandom));
            end
            step();
        end
        Reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
